// File: rtl/spike_rx_fifo.sv
// Receive FIFO behind the spike arbiter tree: buffers {src, data} words with
// first-word fall-through output and keeps saturating per-source push counters.

module spike_src_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle increment; saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                                   cnt_d = '0;
    else if (inc && (cnt_q != {CNT_W{1'b1}}))  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module spike_rx_fifo #(
  parameter int WIDTH = 2,
  parameter int SRC_W = 2,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8,
  localparam int NSRC = 2 ** SRC_W,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SRC_W-1:0]      in_src,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SRC_W-1:0]      out_src,
  output logic [LW-1:0]         level,
  output logic                  full,
  output logic                  empty,
  input  logic                  clr_cnt,
  output logic [NSRC*CNT_W-1:0] src_cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [SRC_W+WIDTH-1:0] mem_q [DEPTH];
  logic                   push, pop;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign level     = level_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately unreset; the head is only meaningful while !empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_src, in_data};
  end

  assign {out_src, out_data} = mem_q[rd_ptr_q];

  for (genvar k = 0; k < NSRC; k++) begin : g_cnt
    spike_src_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_cnt),
      .inc   (push && (in_src == SRC_W'(k))),
      .cnt   (src_cnt[k*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_spike_rx_fifo.sv
// Bench for spike_rx_fifo: a queue-based reference checked every cycle against
// two instances (8-bit and 4-bit counters) driven by the same directed stimulus.

module tb_spike_rx_fifo;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, out_ready, clr_cnt;
  logic [1:0] in_data, in_src;

  logic        in_ready, out_valid, full, empty;
  logic [1:0]  out_data, out_src;
  logic [3:0]  level;
  logic [31:0] src_cnt;

  logic        in_ready4, out_valid4, full4, empty4;
  logic [1:0]  out_data4, out_src4;
  logic [3:0]  level4;
  logic [15:0] src_cnt4;

  int checks = 0;
  int failures = 0;

  spike_rx_fifo #(.WIDTH(2), .SRC_W(2), .DEPTH(D), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_src(in_src), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .level(level), .full(full), .empty(empty),
    .clr_cnt(clr_cnt), .src_cnt(src_cnt));

  spike_rx_fifo #(.WIDTH(2), .SRC_W(2), .DEPTH(D), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_src(in_src), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_src(out_src4), .level(level4), .full(full4), .empty(empty4),
    .clr_cnt(clr_cnt), .src_cnt(src_cnt4));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference: a queue of {src,data} and unsaturated counts since last clear.
  logic [3:0] mq[$];
  int mcnt[4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      foreach (mcnt[k]) mcnt[k] = 0;
    end else begin
      bit pu, po;
      pu = in_valid && (mq.size() < D);
      po = out_ready && (mq.size() > 0);
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back({in_src, in_data});
      if (clr_cnt) foreach (mcnt[k]) mcnt[k] = 0;
      else if (pu) mcnt[in_src]++;
    end
  end

  always @(negedge clk) begin
    int lv;
    lv = mq.size();
    chk("level", 32'(level), 32'(lv));
    chk("level4", 32'(level4), 32'(lv));
    chk("full", 32'(full), 32'(lv == D));
    chk("empty", 32'(empty), 32'(lv == 0));
    chk("in_ready", 32'(in_ready), 32'(lv != D));
    chk("out_valid", 32'(out_valid), 32'(lv != 0));
    chk("out_valid4", 32'(out_valid4), 32'(lv != 0));
    if (lv > 0) begin
      chk("head", 32'({out_src, out_data}), 32'(mq[0]));
      chk("head4", 32'({out_src4, out_data4}), 32'(mq[0]));
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cnt8[%0d]", k), 32'(src_cnt[k*8 +: 8]), 32'(mn(mcnt[k], 255)));
      chk($sformatf("cnt4[%0d]", k), 32'(src_cnt4[k*4 +: 4]), 32'(mn(mcnt[k], 15)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pushes, cyc, sum;
    bit acc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    in_data = '0; in_src = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst empty", 32'(empty), 1);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst level", 32'(level), 0);
    chk("rst cnt", src_cnt, 0);

    // Single push: visible one edge later.
    in_valid = 1'b1; in_data = 2'b10; in_src = 2'd3;
    step();
    in_valid = 1'b0;
    chk("t1 out_valid", 32'(out_valid), 1);
    chk("t1 out_data", 32'(out_data), 2);
    chk("t1 out_src", 32'(out_src), 3);
    chk("t1 level", 32'(level), 1);
    chk("t1 cnt3", 32'(src_cnt[31:24]), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1 empty", 32'(empty), 1);
    chk("t1 level0", 32'(level), 0);

    // Fill, hold a ninth word against full, then drain.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 2'(i); in_src = 2'(i >> 1);
      step();
    end
    chk("t2 full", 32'(full), 1);
    chk("t2 in_ready", 32'(in_ready), 0);
    chk("t2 level8", 32'(level), 8);
    in_data = 2'd3; in_src = 2'd0;
    step();
    chk("t2 held level", 32'(level), 8);
    chk("t2 head", 32'({out_src, out_data}), 0);
    out_ready = 1'b1;
    step();
    chk("t2 first pop level", 32'(level), 7);
    chk("t2 second head", 32'({out_src, out_data}), 1);
    step();
    chk("t2 held accepted level", 32'(level), 7);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("t2 drained", 32'(empty), 1);
    out_ready = 1'b0;

    // Steady push+pop at level 3.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 2'(i + 1); in_src = 2'(i);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 2'($urandom_range(0, 3)); in_src = 2'($urandom_range(0, 3));
      step();
    end
    chk("t3 level3", 32'(level), 3);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b0;

    // Saturation on the 4-bit counters, then clear vs same-cycle push.
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_src = 2'd1; in_data = 2'(i);
      step();
    end
    chk("t4 cnt4[1] sat", 32'(src_cnt4[7:4]), 15);
    chk("t4 cnt8[1]", 32'(src_cnt[15:8]), 20);
    chk("t4 cnt4 others", 32'(src_cnt4 & 16'hFF0F), 0);
    in_data = 2'd3; clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0; in_valid = 1'b0;
    chk("t4 clr cnt4[1]", 32'(src_cnt4[7:4]), 0);
    chk("t4 clr cnt8[1]", 32'(src_cnt[15:8]), 0);
    chk("t4 enq level", 32'(level), 1);
    chk("t4 enq head", 32'({out_src, out_data}), 32'h7);
    step();
    out_ready = 1'b0;

    // Asynchronous reset mid-burst at level 5.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 2'(i); in_src = 2'(3 - (i & 3));
      step();
    end
    in_valid = 1'b0;
    chk("t5 level5", 32'(level), 5);
    rst_n = 1'b0;
    #2;
    chk("t5 async level", 32'(level), 0);
    chk("t5 async empty", 32'(empty), 1);
    chk("t5 async out_valid", 32'(out_valid), 0);
    chk("t5 async in_ready", 32'(in_ready), 1);
    chk("t5 async cnt", src_cnt, 0);
    #4;
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 2'd1; in_src = 2'd2;
    step();
    in_valid = 1'b0;
    chk("t5 post level", 32'(level), 1);
    chk("t5 post head", 32'({out_src, out_data}), 32'h9);
    out_ready = 1'b1;
    step();
    chk("t5 post empty", 32'(empty), 1);
    out_ready = 1'b0;

    // Random leaf traffic with random backpressure: 200 accepted pushes.
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    pushes = 0; cyc = 0;
    while (pushes < 200 && cyc < 5000) begin
      acc = in_valid && in_ready;
      if (acc) pushes++;
      if (acc || !in_valid) begin
        in_valid = (pushes < 200) && ($urandom_range(0, 3) != 0);
        in_data  = 2'($urandom_range(0, 3));
        in_src   = 2'($urandom_range(0, 3));
      end
      out_ready = $urandom_range(0, 1) == 1;
      if (pushes < 200) step();
      cyc++;
    end
    if (cyc >= 5000) chk("t6 timeout", 32'(pushes), 200);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("t6 drained", 32'(empty), 1);
    sum = 0;
    for (int k = 0; k < 4; k++) sum += int'(src_cnt[k*8 +: 8]);
    chk("t6 cnt sum", 32'(sum), 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spike_rx_fifo.md
Name: spike_rx_fifo

Overview:
- Clocked receive buffer directly downstream of the two-level spike arbiter/merge tree.
- Accepts each arbitrated spike word together with its leaf source tag, which encodes the winning leaf of the tree. Buffers words in a FIFO and presents them to the neuron-update stage over valid/ready.
- Keeps saturating per-source packet counters so verification and debug can measure arbitration fairness.

Parameters:
- WIDTH, 2, spike data word width in bits.
- SRC_W, 2, source tag width; NSRC = 2**SRC_W leaf sources (4 for the two-level tree).
- DEPTH, 8, FIFO entries; any value >= 2 (power of two not required).
- CNT_W, 8, width of each per-source counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  FIFO can accept; equals !full.
- in_data  input  WIDTH  spike word.
- in_src  input  SRC_W  leaf source tag (0..NSRC-1).
- out_valid  output  1  head entry available; equals !empty.
- out_ready  input  1  downstream consumes head.
- out_data  output  WIDTH  head entry data (first-word fall-through).
- out_src  output  SRC_W  head entry tag.
- level  output  $clog2(DEPTH+1)  current occupancy.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- clr_cnt  input  1  synchronous clear of all source counters.
- src_cnt  output  NSRC*CNT_W  flattened counters; source k occupies bits [k*CNT_W +: CNT_W].

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr, rd_ptr, and level go to 0; empty=1, full=0, in_ready=1, out_valid=0; all src_cnt=0. out_data and out_src are don't-care while empty; the bench must not check them. The storage array is not reset.
- Reset asserted mid-operation discards all buffered entries immediately. The first cycle after release behaves as an empty FIFO.
- Push: occurs when in_valid && in_ready at a rising edge. Writes {in_src, in_data} at wr_ptr, then advances wr_ptr.
- Pop: occurs when out_valid && out_ready at a rising edge. Advances rd_ptr.
- Latency: a word pushed at edge t is visible on out_* with out_valid=1 immediately after edge t, i.e. one cycle, when the FIFO was empty. There is no combinational in->out bypass.
- Pointers wrap explicitly from DEPTH-1 to 0.
- level changes as follows:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop.
- Full: in_ready=0, so no push can occur even if a pop happens in the same cycle. The upstream holds its word.
- Empty: out_valid=0, so out_ready is ignored.
- Simultaneous push and pop with 0 < level < DEPTH: both occur and level holds.
- Handshake rules:
  - Upstream must hold in_data and in_src stable while in_valid=1 && in_ready=0.
  - out_data and out_src stay stable while out_valid=1 && out_ready=0.
  - out_valid never drops without a pop, except on reset.
- Counters: on each push, src_cnt[in_src] increments by 1 and saturates at 2**CNT_W-1 with no wrap. clr_cnt=1 zeroes all counters at the edge, and this takes precedence over a same-cycle increment (the result is 0, not 1). clr_cnt does not affect the FIFO.
- Ordering: strict FIFO; tags always stay paired with their data.

Test Plan:
- Reset then single push (data=2'b10, src=3): after one edge out_valid=1, out_data=2, out_src=3, level=1, src_cnt[3]=1. Pop with out_ready=1 gives empty=1 and level=0.
- Fill with 8 pushes, out_ready=0: full=1, in_ready=0. Ninth word held with in_valid=1 is not accepted and level stays 8. Drain with out_ready=1 returns the 8 words in order. The held word is accepted on the first cycle that full=0.
- Continuous push and pop at level=3 for 20 cycles with a random sequence of words: level stays 3, output sequence equals input sequence, and pointers wrap at least twice without error.
- Counter saturation with CNT_W=4: push 20 words with src=1, then src_cnt[1]=15 and other counters=0. Then assert clr_cnt together with a src=1 push: src_cnt[1]=0 afterwards, and the word is still enqueued.
- Assert rst_n=0 mid-burst at level=5 for half a cycle: outputs go to reset values immediately (asynchronously), level=0. After release, the next push/pop behaves as from empty.
- Drive from 4 random leaf sources through the arbiter model for 200 pushes with random out_ready: no loss or reorder, and the sum of src_cnt equals 200.
